// File: rtl/reset_sequencer.sv
// Multi-channel reset sequencer: holds all channels, then releases them one by one with a
// fixed gap; a software request re-runs the sequence on a chosen subset of channels.
module reset_sequencer #(
    parameter int unsigned NCH           = 4,
    parameter int unsigned ASSERT_CYCLES = 8,
    parameter int unsigned GAP           = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           sw_rst_req,
    input  logic [NCH-1:0] ch_mask,
    output logic [NCH-1:0] out_rst_n,
    output logic           done,
    output logic           sw_rst_ack
);

    localparam int unsigned MaxCnt = (ASSERT_CYCLES > GAP) ? ASSERT_CYCLES : GAP;
    localparam int unsigned CntW   = $clog2(MaxCnt + 1);
    localparam int unsigned StgW   = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [CntW-1:0] HoldEnd = CntW'(ASSERT_CYCLES);
    localparam logic [CntW-1:0] GapEnd  = CntW'(GAP);
    localparam logic [StgW-1:0] LastStg = StgW'(NCH - 1);

    typedef enum logic [1:0] {StHold, StStage, StRun} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [StgW-1:0] stg_q, stg_d;
    logic [NCH-1:0]  sel_q, sel_d;
    logic [NCH-1:0]  out_q, out_d;
    logic            done_q, done_d;
    logic            ack_q, ack_d;
    logic [StgW-1:0] stg_inc;
    logic [NCH-1:0]  stg_bit;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stg_d   = stg_q;
        sel_d   = sel_q;
        out_d   = out_q;
        done_d  = done_q;
        ack_d   = 1'b0;
        stg_inc = stg_q + StgW'(1);
        stg_bit = NCH'(1) << stg_inc;

        unique case (state_q)
            StHold: begin
                if (cnt_q == HoldEnd) begin
                    out_d = out_q | (sel_q & NCH'(1));
                    stg_d = '0;
                    cnt_d = CntW'(1);
                    if (NCH == 1) begin
                        state_d = StRun;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StStage;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StStage: begin
                // Every index is visited so release timing is independent of the mask.
                if (cnt_q == GapEnd) begin
                    out_d = out_q | (sel_q & stg_bit);
                    stg_d = stg_inc;
                    cnt_d = CntW'(1);
                    if (stg_inc == LastStg) begin
                        state_d = StRun;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StRun: begin
                if (sw_rst_req && (ch_mask != '0)) begin
                    sel_d   = ch_mask;
                    out_d   = out_q & ~ch_mask;
                    done_d  = 1'b0;
                    ack_d   = 1'b1;
                    state_d = StHold;
                    // The accepting edge already counts as the first held cycle.
                    cnt_d   = CntW'(1);
                end
            end
            default: state_d = StHold;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StHold;
            cnt_q   <= '0;
            stg_q   <= '0;
            sel_q   <= '1;
            out_q   <= '0;
            done_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stg_q   <= stg_d;
            sel_q   <= sel_d;
            out_q   <= out_d;
            done_q  <= done_d;
            ack_q   <= ack_d;
        end
    end

    assign out_rst_n  = out_q;
    assign done       = done_q;
    assign sw_rst_ack = ack_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: three configurations checked every cycle against a model that
// derives each output from the release-time formula relative to the sequence start edge.
module tb_reset_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc      = 0;
    int n_checks = 0;
    int n_fail   = 0;

    // Config A: defaults
    logic        a_rst_n, a_req, a_done, a_ack;
    logic [3:0]  a_mask, a_out;
    // Config B: NCH=1, ASSERT=1, GAP=1
    logic        b_rst_n, b_req, b_done, b_ack;
    logic [0:0]  b_mask, b_out;
    // Config C: NCH=32, GAP=1
    logic        c_rst_n, c_req, c_done, c_ack;
    logic [31:0] c_mask, c_out;

    reset_sequencer #(.NCH(4), .ASSERT_CYCLES(8), .GAP(4)) u_a (
        .clk(clk), .rst_n(a_rst_n), .sw_rst_req(a_req), .ch_mask(a_mask),
        .out_rst_n(a_out), .done(a_done), .sw_rst_ack(a_ack)
    );
    reset_sequencer #(.NCH(1), .ASSERT_CYCLES(1), .GAP(1)) u_b (
        .clk(clk), .rst_n(b_rst_n), .sw_rst_req(b_req), .ch_mask(b_mask),
        .out_rst_n(b_out), .done(b_done), .sw_rst_ack(b_ack)
    );
    reset_sequencer #(.NCH(32), .ASSERT_CYCLES(8), .GAP(1)) u_c (
        .clk(clk), .rst_n(c_rst_n), .sw_rst_req(c_req), .ch_mask(c_mask),
        .out_rst_n(c_out), .done(c_done), .sw_rst_ack(c_ack)
    );

    // Model: per config, the start edge e0, selected set, and values of unselected channels.
    int          pn[3] = '{4, 1, 32};
    int          pa[3] = '{8, 1, 8};
    int          pg[3] = '{4, 1, 1};
    logic        m_inrst[3];
    int          m_e0[3];
    logic [31:0] m_sel[3];
    logic [31:0] m_base[3];
    logic        m_ack[3];

    function automatic logic [31:0] f_out(int d, int k);
        logic [31:0] r;
        r = '0;
        if (!m_inrst[d]) begin
            for (int i = 0; i < pn[d]; i++) begin
                r[i] = m_sel[d][i] ? (k >= m_e0[d] + pa[d] + i * pg[d]) : m_base[d][i];
            end
        end
        return r;
    endfunction

    function automatic logic f_done(int d, int k);
        return !m_inrst[d] && (k >= m_e0[d] + pa[d] + (pn[d] - 1) * pg[d]);
    endfunction

    // Advance one clock: update the model at the rising edge, return at the falling edge.
    task automatic step();
        logic [31:0] prev[3];
        logic        pdone[3];
        logic        rs[3];
        logic        rq[3];
        logic [31:0] mk[3];
        rs[0] = a_rst_n; rq[0] = a_req; mk[0] = 32'(a_mask);
        rs[1] = b_rst_n; rq[1] = b_req; mk[1] = 32'(b_mask);
        rs[2] = c_rst_n; rq[2] = c_req; mk[2] = c_mask;
        for (int d = 0; d < 3; d++) begin
            prev[d]  = f_out(d, cyc);
            pdone[d] = f_done(d, cyc);
        end
        @(posedge clk);
        cyc++;
        for (int d = 0; d < 3; d++) begin
            m_ack[d] = 1'b0;
            if (!rs[d]) begin
                m_inrst[d] = 1'b1;
                m_sel[d]   = '1;
                m_base[d]  = '0;
            end else if (m_inrst[d]) begin
                m_inrst[d] = 1'b0;
                m_e0[d]    = cyc;
            end else if (pdone[d] && rq[d] && (mk[d] != '0)) begin
                m_e0[d]   = cyc;
                m_base[d] = prev[d] & ~mk[d];
                m_sel[d]  = mk[d];
                m_ack[d]  = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] ea, eb, ec;
        a_rst_n = 1'b0; b_rst_n = 1'b0; c_rst_n = 1'b0;
        repeat ($urandom_range(2, 5)) begin
            step();
            n_checks += 3;
            if (a_out !== 4'b0000 || a_done !== 1'b0 || a_ack !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_a cyc=%0d got out=%b done=%b ack=%b required 0000/0/0",
                         cyc, a_out, a_done, a_ack);
            end
            if (b_out !== 1'b0 || b_done !== 1'b0 || b_ack !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_b cyc=%0d got out=%b done=%b ack=%b required 0/0/0",
                         cyc, b_out, b_done, b_ack);
            end
            if (c_out !== 32'h0 || c_done !== 1'b0 || c_ack !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_c cyc=%0d got out=%h done=%b ack=%b required 0/0/0",
                         cyc, c_out, c_done, c_ack);
            end
        end
        a_rst_n = 1'b1; b_rst_n = 1'b1; c_rst_n = 1'b1;
        repeat (45) begin
            step();
            ea = f_out(0, cyc); eb = f_out(1, cyc); ec = f_out(2, cyc);
            n_checks += 6;
            if (a_out !== ea[3:0] || a_done !== f_done(0, cyc)) begin
                n_fail++;
                $display("FAIL powerup_a cyc=%0d got out=%b done=%b required out=%b done=%b",
                         cyc, a_out, a_done, ea[3:0], f_done(0, cyc));
            end
            if (b_out !== eb[0:0] || b_done !== f_done(1, cyc)) begin
                n_fail++;
                $display("FAIL powerup_b cyc=%0d got out=%b done=%b required out=%b done=%b",
                         cyc, b_out, b_done, eb[0], f_done(1, cyc));
            end
            if (c_out !== ec || c_done !== f_done(2, cyc)) begin
                n_fail++;
                $display("FAIL powerup_c cyc=%0d got out=%h done=%b required out=%h done=%b",
                         cyc, c_out, c_done, ec, f_done(2, cyc));
            end
            if (a_ack !== 1'b0) begin
                n_fail++;
                $display("FAIL powerup_a_ack cyc=%0d got %b required 0", cyc, a_ack);
            end
            if (b_ack !== 1'b0) begin
                n_fail++;
                $display("FAIL powerup_b_ack cyc=%0d got %b required 0", cyc, b_ack);
            end
            if (c_ack !== 1'b0) begin
                n_fail++;
                $display("FAIL powerup_c_ack cyc=%0d got %b required 0", cyc, c_ack);
            end
        end
        // Full release of config A is fixed by the default timing: all high, done set.
        n_checks++;
        if (a_out !== 4'b1111 || a_done !== 1'b1) begin
            n_fail++;
            $display("FAIL powerup_a_final got out=%b done=%b required 1111/1", a_out, a_done);
        end
    endtask

    // Masked SW reset on config A, with requests fired during the sequence (must be ignored).
    task automatic test_sw_mask();
        logic [31:0] ea;
        a_req = 1'b1; a_mask = 4'b1010;
        for (int t = 0; t < 24; t++) begin
            step();
            a_req  = (t < 17) ? 1'($urandom_range(0, 1)) : 1'b0;
            a_mask = 4'($urandom_range(0, 15));
            ea = f_out(0, cyc);
            n_checks += 3;
            if (a_out !== ea[3:0]) begin
                n_fail++;
                $display("FAIL sw_mask_out cyc=%0d got %b required %b", cyc, a_out, ea[3:0]);
            end
            if (a_done !== f_done(0, cyc)) begin
                n_fail++;
                $display("FAIL sw_mask_done cyc=%0d got %b required %b", cyc, a_done,
                         f_done(0, cyc));
            end
            if (a_ack !== m_ack[0]) begin
                n_fail++;
                $display("FAIL sw_mask_ack cyc=%0d got %b required %b", cyc, a_ack, m_ack[0]);
            end
        end
        a_req = 1'b0;
    endtask

    // Random requests, zero masks and occasional mid-sequence master resets on config A.
    task automatic test_random_a();
        logic [31:0] ea;
        for (int t = 0; t < 300; t++) begin
            a_req   = ($urandom_range(0, 2) == 0);
            a_mask  = 4'($urandom_range(0, 15));
            a_rst_n = ($urandom_range(0, 39) != 0);
            step();
            ea = f_out(0, cyc);
            n_checks += 3;
            if (a_out !== ea[3:0]) begin
                n_fail++;
                $display("FAIL rand_a_out cyc=%0d got %b required %b", cyc, a_out, ea[3:0]);
            end
            if (a_done !== f_done(0, cyc)) begin
                n_fail++;
                $display("FAIL rand_a_done cyc=%0d got %b required %b", cyc, a_done,
                         f_done(0, cyc));
            end
            if (a_ack !== m_ack[0]) begin
                n_fail++;
                $display("FAIL rand_a_ack cyc=%0d got %b required %b", cyc, a_ack, m_ack[0]);
            end
        end
        a_req = 1'b0; a_rst_n = 1'b1;
        repeat (25) step();
    endtask

    // Master reset landing 14 edges into a SW sequence, then a full restart.
    task automatic test_abort();
        logic [31:0] ea;
        a_req = 1'b1; a_mask = 4'b1111;
        step();
        a_req = 1'b0;
        n_checks++;
        if (a_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_ack cyc=%0d got %b required 1", cyc, a_ack);
        end
        repeat (13) step();
        a_rst_n = 1'b0;
        step();
        n_checks++;
        if (a_out !== 4'b0000 || a_done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_low cyc=%0d got out=%b done=%b required 0000/0", cyc, a_out,
                     a_done);
        end
        a_rst_n = 1'b1;
        repeat (24) begin
            step();
            ea = f_out(0, cyc);
            n_checks += 2;
            if (a_out !== ea[3:0]) begin
                n_fail++;
                $display("FAIL abort_out cyc=%0d got %b required %b", cyc, a_out, ea[3:0]);
            end
            if (a_done !== f_done(0, cyc)) begin
                n_fail++;
                $display("FAIL abort_done cyc=%0d got %b required %b", cyc, a_done,
                         f_done(0, cyc));
            end
        end
    endtask

    // Config B with the request held high: an ACK may only follow a completed sequence.
    task automatic test_back_to_back();
        logic [31:0] eb;
        b_req = 1'b1; b_mask = 1'b1;
        for (int t = 0; t < 60; t++) begin
            step();
            if (t >= 20) begin
                b_req  = 1'($urandom_range(0, 1));
                b_mask = 1'($urandom_range(0, 1));
            end
            eb = f_out(1, cyc);
            n_checks += 3;
            if (b_out !== eb[0:0]) begin
                n_fail++;
                $display("FAIL b2b_out cyc=%0d got %b required %b", cyc, b_out, eb[0]);
            end
            if (b_done !== f_done(1, cyc)) begin
                n_fail++;
                $display("FAIL b2b_done cyc=%0d got %b required %b", cyc, b_done, f_done(1, cyc));
            end
            if (b_ack !== m_ack[1]) begin
                n_fail++;
                $display("FAIL b2b_ack cyc=%0d got %b required %b", cyc, b_ack, m_ack[1]);
            end
        end
        b_req = 1'b0;
    endtask

    // Config C: the two end channels, then a couple of random masks.
    task automatic test_nch32();
        logic [31:0] ec;
        for (int r = 0; r < 3; r++) begin
            c_req  = 1'b1;
            c_mask = (r == 0) ? 32'h8000_0001 : ($urandom() | 32'h1);
            for (int t = 0; t < 42; t++) begin
                step();
                c_req = 1'b0;
                ec = f_out(2, cyc);
                n_checks += 3;
                if (c_out !== ec) begin
                    n_fail++;
                    $display("FAIL nch32_out cyc=%0d got %h required %h", cyc, c_out, ec);
                end
                if (c_done !== f_done(2, cyc)) begin
                    n_fail++;
                    $display("FAIL nch32_done cyc=%0d got %b required %b", cyc, c_done,
                             f_done(2, cyc));
                end
                if (c_ack !== m_ack[2]) begin
                    n_fail++;
                    $display("FAIL nch32_ack cyc=%0d got %b required %b", cyc, c_ack, m_ack[2]);
                end
            end
        end
    endtask

    initial begin
        a_req = 1'b0; a_mask = '0;
        b_req = 1'b0; b_mask = '0;
        c_req = 1'b0; c_mask = '0;
        a_rst_n = 1'b0; b_rst_n = 1'b0; c_rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            m_inrst[d] = 1'b1;
            m_e0[d]    = 0;
            m_sel[d]   = '1;
            m_base[d]  = '0;
            m_ack[d]   = 1'b0;
        end
        test_reset();
        test_sw_mask();
        test_abort();
        test_random_a();
        test_back_to_back();
        test_nch32();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
